// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM region blocks.
package vram_pkg;

  // Clear engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Supported read latencies; 2 adds an output register after the RAM.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Per-region geometry used when instantiating the four VRAM regions.
  localparam int TILE_ADDR_W    = 11;
  localparam int TILE_DATA_W    = 64;
  localparam int PATTERN_ADDR_W = 12;
  localparam int PATTERN_DATA_W = 64;
  localparam int PALETTE_ADDR_W = 8;
  localparam int PALETTE_DATA_W = 32;
  localparam int SPRITE_ADDR_W  = 7;
  localparam int SPRITE_DATA_W  = 64;

endpackage

// File: rtl/vram_dpram.sv
// True dual-port RAM: port A read-only, port B read/write with byte enables.
// Both read ports have a one-cycle registered output that only updates on a
// read, so the data holds between reads. A read that collides with a port B
// write to the same address returns the old word.
module vram_dpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rddata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BE_W-1:0]   b_byteena,
  input  logic [DATA_W-1:0] b_wrdata,
  output logic [DATA_W-1:0] b_rddata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port B write, one byte lane per enable bit; contents are never reset
  always_ff @(posedge clk) begin
    if (b_en && b_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (b_byteena[k]) begin
          mem[b_addr][k*8 +: 8] <= b_wrdata[k*8 +: 8];
        end
      end
    end
  end

  // Port A read register, updated only on a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rddata <= '0;
    end else if (a_en) begin
      a_rddata <= mem[a_addr];
    end
  end

  // Port B read register, updated only on a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rddata <= '0;
    end else if (b_en && !b_we) begin
      b_rddata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/vram_region.sv
// One VRAM region (tile, pattern, palette or sprite). The PPU reads through
// port A and is never stalled. The CPU uses port B through a req/ack
// handshake; the clear engine takes port B over while it fills the region.
//
// Handshake: cpu_req is held with cpu_we/cpu_addr/cpu_byteena/cpu_wrdata
// stable until cpu_ack is seen high; the access happens in that ack cycle.
// cpu_ack is combinational and only high in IDLE when no clear is starting,
// so a clr_start in the same cycle wins and the request waits for IDLE.
module vram_region
  import vram_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ppu_rden,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_rddata,
  output logic              ppu_rdvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BE_W-1:0]   cpu_byteena,
  input  logic [DATA_W-1:0] cpu_wrdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rddata,
  output logic              cpu_rdvalid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  // Any value other than 2 behaves as a single-cycle read.
  localparam int LAT = (RD_LAT == RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  // Counter is one bit wider than the address so DEPTH is reachable.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  clr_state_e        state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] clr_word;

  logic              b_en;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [BE_W-1:0]   b_byteena;
  logic [DATA_W-1:0] b_wrdata;

  logic [DATA_W-1:0] ppu_ram_q;
  logic [DATA_W-1:0] cpu_ram_q;
  logic              ppu_v1;
  logic              cpu_v1;

  assign cpu_ack = cpu_req & (state == ST_IDLE) & ~clr_start;

  // Port B source select: clear engine while clearing, otherwise the CPU
  always_comb begin
    b_en      = cpu_ack;
    b_we      = cpu_we;
    b_addr    = cpu_addr;
    b_byteena = cpu_byteena;
    b_wrdata  = cpu_wrdata;
    if (state == ST_CLEAR) begin
      b_en      = 1'b1;
      b_we      = 1'b1;
      b_addr    = clr_cnt[ADDR_W-1:0];
      b_byteena = '1;
      b_wrdata  = clr_word;
    end
  end

  // Clear engine FSM with registered busy/done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      clr_word <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_word <= clr_value;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + CNT_ONE;
          if (clr_cnt == CNT_LAST) begin
            state    <= ST_DONE;
            clr_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // First valid stage, aligned with the RAM output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_v1 <= 1'b0;
      cpu_v1 <= 1'b0;
    end else begin
      ppu_v1 <= ppu_rden;
      cpu_v1 <= cpu_ack & ~cpu_we;
    end
  end

  vram_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_en      (ppu_rden),
    .a_addr    (ppu_addr),
    .a_rddata  (ppu_ram_q),
    .b_en      (b_en),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_byteena (b_byteena),
    .b_wrdata  (b_wrdata),
    .b_rddata  (cpu_ram_q)
  );

  generate
    if (LAT == RD_LAT_MAX) begin : g_lat2
      logic              ppu_v2;
      logic              cpu_v2;
      logic [DATA_W-1:0] ppu_q2;
      logic [DATA_W-1:0] cpu_q2;

      // Extra output stage; data registers load only with a valid word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ppu_v2 <= 1'b0;
          cpu_v2 <= 1'b0;
          ppu_q2 <= '0;
          cpu_q2 <= '0;
        end else begin
          ppu_v2 <= ppu_v1;
          cpu_v2 <= cpu_v1;
          if (ppu_v1) ppu_q2 <= ppu_ram_q;
          if (cpu_v1) cpu_q2 <= cpu_ram_q;
        end
      end

      assign ppu_rdvalid = ppu_v2;
      assign ppu_rddata  = ppu_q2;
      assign cpu_rdvalid = cpu_v2;
      assign cpu_rddata  = cpu_q2;
    end else begin : g_lat1
      assign ppu_rdvalid = ppu_v1;
      assign ppu_rddata  = ppu_ram_q;
      assign cpu_rdvalid = cpu_v1;
      assign cpu_rddata  = cpu_ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_vram_region.sv
// Bench for vram_region: u_l1 is a 32-word RD_LAT=1 region, u_l2 a 16-word
// RD_LAT=2 region. Expected data comes from word arrays updated with the
// byte-lane write rule and the clear fill rule.
module tb_vram_region;

  localparam int DW     = 64;
  localparam int AW1    = 5;
  localparam int AW2    = 4;
  localparam int DEPTH1 = 32;
  localparam int DEPTH2 = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic           p1_rden = 0;
  logic [AW1-1:0] p1_addr = '0;
  logic [DW-1:0]  p1_rddata;
  logic           p1_rdvalid;
  logic           c1_req = 0, c1_we = 0;
  logic [AW1-1:0] c1_addr = '0;
  logic [7:0]     c1_be = '0;
  logic [DW-1:0]  c1_wrdata = '0;
  logic           c1_ack;
  logic [DW-1:0]  c1_rddata;
  logic           c1_rdvalid;
  logic           k1_start = 0;
  logic [DW-1:0]  k1_value = '0;
  logic           k1_busy, k1_done;

  logic           p2_rden = 0;
  logic [AW2-1:0] p2_addr = '0;
  logic [DW-1:0]  p2_rddata;
  logic           p2_rdvalid;
  logic           c2_req = 0, c2_we = 0;
  logic [AW2-1:0] c2_addr = '0;
  logic [7:0]     c2_be = '0;
  logic [DW-1:0]  c2_wrdata = '0;
  logic           c2_ack;
  logic [DW-1:0]  c2_rddata;
  logic           c2_rdvalid;
  logic           k2_start = 0;
  logic [DW-1:0]  k2_value = '0;
  logic           k2_busy, k2_done;

  vram_region #(.ADDR_W(AW1), .DATA_W(DW), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .ppu_rden(p1_rden), .ppu_addr(p1_addr), .ppu_rddata(p1_rddata), .ppu_rdvalid(p1_rdvalid),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_byteena(c1_be),
    .cpu_wrdata(c1_wrdata), .cpu_ack(c1_ack), .cpu_rddata(c1_rddata), .cpu_rdvalid(c1_rdvalid),
    .clr_start(k1_start), .clr_value(k1_value), .clr_busy(k1_busy), .clr_done(k1_done)
  );

  vram_region #(.ADDR_W(AW2), .DATA_W(DW), .RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .ppu_rden(p2_rden), .ppu_addr(p2_addr), .ppu_rddata(p2_rddata), .ppu_rdvalid(p2_rdvalid),
    .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr), .cpu_byteena(c2_be),
    .cpu_wrdata(c2_wrdata), .cpu_ack(c2_ack), .cpu_rddata(c2_rddata), .cpu_rdvalid(c2_rdvalid),
    .clr_start(k2_start), .clr_value(k2_value), .clr_busy(k2_busy), .clr_done(k2_done)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] mem1 [DEPTH1];
  logic [DW-1:0] mem2 [DEPTH2];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_cpu1 = '0, last_ppu1 = '0, last_cpu2 = '0, last_ppu2 = '0;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // New word after a write: enabled lanes take the new byte, others keep the old one.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] d,
                                          input logic [7:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int k = 0; k < 8; k++) if (be[k]) mask = mask | (64'hFF << (8 * k));
    return (old_w & ~mask) | (d & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu1_write(input logic [AW1-1:0] a, input logic [7:0] be, input logic [DW-1:0] d);
    c1_req = 1; c1_we = 1; c1_addr = a; c1_be = be; c1_wrdata = d;
    @(negedge clk);
    check("l1_wr_ack", 64'(c1_ack), 64'd1);
    tick();
    c1_req = 0; c1_we = 0;
    mem1[a] = merge(mem1[a], d, be);
    check("l1_wr_no_rdvalid", 64'(c1_rdvalid), 64'd0);
    check("l1_rddata_hold", c1_rddata, last_cpu1);
  endtask

  task automatic cpu1_read(input logic [AW1-1:0] a);
    c1_req = 1; c1_we = 0; c1_addr = a;
    @(negedge clk);
    check("l1_rd_ack", 64'(c1_ack), 64'd1);
    tick();
    c1_req = 0;
    check("l1_rdvalid", 64'(c1_rdvalid), 64'd1);
    check("l1_rddata", c1_rddata, mem1[a]);
    last_cpu1 = mem1[a];
    tick();
    check("l1_rdvalid_pulse", 64'(c1_rdvalid), 64'd0);
  endtask

  task automatic cpu2_read(input logic [AW2-1:0] a);
    c2_req = 1; c2_we = 0; c2_addr = a;
    @(negedge clk);
    check("l2_rd_ack", 64'(c2_ack), 64'd1);
    tick();
    c2_req = 0;
    check("l2_rdvalid_early", 64'(c2_rdvalid), 64'd0);
    tick();
    check("l2_rdvalid", 64'(c2_rdvalid), 64'd1);
    check("l2_rddata", c2_rddata, mem2[a]);
    last_cpu2 = mem2[a];
    tick();
    check("l2_rdvalid_pulse", 64'(c2_rdvalid), 64'd0);
    check("l2_rddata_hold", c2_rddata, last_cpu2);
  endtask

  // Clear of u_l2; optionally with a CPU write raised in the clr_start cycle.
  task automatic clr2_run(input logic [DW-1:0] v, input bit with_req,
                          input logic [AW2-1:0] ra, input logic [DW-1:0] rd);
    int busy_n, done_n, ack_n;
    bit idle_seen;
    busy_n = 0; done_n = 0; ack_n = 0; idle_seen = 0;
    k2_start = 1; k2_value = v;
    if (with_req) begin
      c2_req = 1; c2_we = 1; c2_addr = ra; c2_be = 8'hFF; c2_wrdata = rd;
    end
    @(negedge clk);
    check("l2_clr_start_beats_req", 64'(c2_ack), 64'd0);
    tick();
    k2_start = 0; k2_value = ~v;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!k2_busy) begin
        idle_seen = 1;
        check("l2_ack_first_idle", 64'(c2_ack), 64'(with_req));
        break;
      end
      busy_n++;
      if (k2_done) done_n++;
      if (c2_ack) ack_n++;
      k2_start = (i == 5);   // restart attempt mid-clear must be ignored
      k2_value = {$urandom, $urandom};
      tick();
    end
    k2_start = 0;
    tick();
    c2_req = 0; c2_we = 0;
    check("l2_clr_finished", 64'(idle_seen), 64'd1);
    check("l2_clr_busy_cycles", 64'(busy_n), 64'(DEPTH2 + 1));
    check("l2_clr_done_pulses", 64'(done_n), 64'd1);
    check("l2_no_ack_while_busy", 64'(ack_n), 64'd0);
    for (int j = 0; j < DEPTH2; j++) mem2[j] = v;
    if (with_req) mem2[ra] = rd;
  endtask

  // PPU streaming on u_l2 with optional CPU writes; valids checked against rden delayed 2.
  task automatic ppu2_stream(input int n, input bit directed, input int coll_idx,
                             input logic [DW-1:0] coll_data);
    bit sched [64];
    bit rd, wr;
    logic [AW2-1:0] a, wa;
    logic [DW-1:0]  wd, e;
    logic [7:0]     wbe;
    for (int i = 0; i < 64; i++) sched[i] = 0;
    exp_q.delete();
    for (int i = 0; i < n + 4; i++) begin
      rd = 0; wr = 0; a = '0; wa = '0; wd = '0; wbe = '0;
      if (i < n) begin
        rd  = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        a   = directed ? AW2'(i) : AW2'($urandom_range(0, DEPTH2 - 1));
        wr  = directed ? (i == coll_idx) : ($urandom_range(0, 2) == 0);
        wa  = (directed || $urandom_range(0, 1) == 0) ? a : AW2'($urandom_range(0, DEPTH2 - 1));
        wd  = directed ? coll_data : {$urandom, $urandom};
        wbe = directed ? 8'hFF : 8'($urandom_range(0, 255));
      end
      p2_rden = rd; p2_addr = a;
      c2_req = wr; c2_we = wr; c2_addr = wa; c2_be = wbe; c2_wrdata = wd;
      if (rd) begin
        sched[i + 2] = 1;
        exp_q.push_back(mem2[a]);
      end
      @(negedge clk);
      check("l2_ppu_rdvalid", 64'(p2_rdvalid), 64'(sched[i]));
      if (p2_rdvalid) begin
        if (exp_q.size() == 0) begin
          check("l2_ppu_unexpected_valid", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("l2_ppu_rddata", p2_rddata, e);
          last_ppu2 = e;
        end
      end else begin
        check("l2_ppu_rddata_hold", p2_rddata, last_ppu2);
      end
      if (wr) check("l2_wr_ack", 64'(c2_ack), 64'd1);
      tick();
      if (wr) mem2[wa] = merge(mem2[wa], wd, wbe);
    end
    p2_rden = 0; c2_req = 0; c2_we = 0;
    check("l2_ppu_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_checks();
    check("rst_l1_ppu_rdvalid", 64'(p1_rdvalid), 64'd0);
    check("rst_l1_ppu_rddata", p1_rddata, 64'd0);
    check("rst_l1_cpu_rdvalid", 64'(c1_rdvalid), 64'd0);
    check("rst_l1_cpu_rddata", c1_rddata, 64'd0);
    check("rst_l1_busy_done", {k1_busy, k1_done}, 64'd0);
    check("rst_l2_ppu_rdvalid", 64'(p2_rdvalid), 64'd0);
    check("rst_l2_ppu_rddata", p2_rddata, 64'd0);
    check("rst_l2_cpu_rdvalid", 64'(c2_rdvalid), 64'd0);
    check("rst_l2_cpu_rddata", c2_rddata, 64'd0);
    check("rst_l2_busy_done", {k2_busy, k2_done}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  int busy_n, done_n;
  bit pr;
  int op;
  logic [AW1-1:0] pa, ca;
  logic [7:0]     be;
  logic [DW-1:0]  d, pexp, cexp;
  logic [DW-1:0]  v;

  initial begin
    // reset
    #2 rst_n = 0;
    tick(); tick();
    reset_checks();
    #2 rst_n = 1;
    tick();

    // u_l1: clear to zero while the PPU keeps reading
    k1_value = '0; k1_start = 1; p1_rden = 1; p1_addr = '0;
    tick();
    k1_start = 0; k1_value = '1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("l1_ppu_not_stalled", 64'(p1_rdvalid), 64'd1);
      if (!k1_busy) break;
      busy_n++;
      if (k1_done) done_n++;
      p1_addr = AW1'($urandom_range(0, DEPTH1 - 1));
      tick();
    end
    p1_rden = 0;
    tick();
    check("l1_clr_busy_cycles", 64'(busy_n), 64'(DEPTH1 + 1));
    check("l1_clr_done_pulses", 64'(done_n), 64'd1);
    for (int j = 0; j < DEPTH1; j++) mem1[j] = '0;
    last_ppu1 = '0;

    // u_l1: directed write/read and byte lanes
    cpu1_write(5'h10, 8'hFF, 64'h1122334455667788);
    cpu1_read(5'h10);
    check("l1_tp_write_read", c1_rddata, 64'h1122334455667788);
    cpu1_write(5'd5, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    cpu1_read(5'd5);
    check("l1_tp_byte_lanes", c1_rddata, 64'h0000_0000_FFFF_FFFF);
    cpu1_write(5'd7, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    cpu1_read(5'd7);

    // u_l1: random single-cycle CPU ops alongside PPU reads
    for (int i = 0; i < 80; i++) begin
      pr = ($urandom_range(0, 3) != 0);
      pa = AW1'($urandom_range(0, DEPTH1 - 1));
      op = $urandom_range(0, 2);
      ca = ($urandom_range(0, 3) == 0) ? pa : AW1'($urandom_range(0, DEPTH1 - 1));
      be = 8'($urandom_range(0, 255));
      d  = {$urandom, $urandom};
      p1_rden = pr; p1_addr = pa;
      c1_req = (op != 0); c1_we = (op == 1); c1_addr = ca; c1_be = be; c1_wrdata = d;
      pexp = mem1[pa];
      cexp = mem1[ca];
      @(negedge clk);
      check("l1_rand_ack", 64'(c1_ack), 64'(op != 0));
      tick();
      if (pr) begin
        check("l1_rand_ppu_rdvalid", 64'(p1_rdvalid), 64'd1);
        check("l1_rand_ppu_rddata", p1_rddata, pexp);
        last_ppu1 = pexp;
      end else begin
        check("l1_rand_ppu_rdvalid", 64'(p1_rdvalid), 64'd0);
        check("l1_rand_ppu_hold", p1_rddata, last_ppu1);
      end
      if (op == 2) begin
        check("l1_rand_cpu_rdvalid", 64'(c1_rdvalid), 64'd1);
        check("l1_rand_cpu_rddata", c1_rddata, cexp);
        last_cpu1 = cexp;
      end else begin
        check("l1_rand_cpu_rdvalid", 64'(c1_rdvalid), 64'd0);
        check("l1_rand_cpu_hold", c1_rddata, last_cpu1);
      end
      if (op == 1) mem1[ca] = merge(mem1[ca], d, be);
    end
    p1_rden = 0; c1_req = 0; c1_we = 0;
    tick();

    // u_l2: clear racing a CPU write, then stream all addresses with a collision at 3
    clr2_run({8{8'hA5}}, 1'b1, 4'd9, 64'h0123_4567_89AB_CDEF);
    ppu2_stream(16, 1'b1, 3, 64'hCAFE_F00D_1234_5678);
    cpu2_read(4'd3);
    cpu2_read(4'd9);
    ppu2_stream(40, 1'b0, -1, '0);
    cpu2_read(AW2'($urandom_range(0, DEPTH2 - 1)));

    // u_l2: reset while the clear counter is at 7 with PPU reads in flight
    k2_start = 1; k2_value = {8{8'h5A}};
    tick();
    k2_start = 0;
    repeat (5) tick();
    p2_rden = 1; p2_addr = 4'd15;
    tick(); tick();
    check("l2_busy_before_reset", 64'(k2_busy), 64'd1);
    check("l2_valid_before_reset", 64'(p2_rdvalid), 64'd1);
    #2 rst_n = 0;
    #1;
    p2_rden = 0;
    reset_checks();
    tick();
    reset_checks();
    #2 rst_n = 1;
    last_cpu1 = '0; last_ppu1 = '0; last_cpu2 = '0; last_ppu2 = '0;
    for (int j = 0; j < 7; j++) mem2[j] = {8{8'h5A}};
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (k2_done || k2_busy) done_n++;
    end
    check("l2_no_done_after_reset", 64'(done_n), 64'd0);

    // partial clear visible, then a full clear after reset
    ppu2_stream(16, 1'b1, -1, '0);
    v = {$urandom, $urandom};
    clr2_run(v, 1'b0, '0, '0);
    ppu2_stream(16, 1'b1, -1, '0);

    // u_l1 contents survive reset
    cpu1_read(5'h10);
    cpu1_read(5'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_region.md
Name: vram_region

Overview:
- Parametrised VRAM region; one instance stands for one of tile, pattern, palette or sprite RAM.
- Wraps a true dual-port RAM.
- PPU side (port A): fixed-latency, read-only pipeline with a valid strobe.
- CPU side (port B): req/ack handshake with byte-enable writes and a read-valid strobe, plus a hardware clear engine that fills the region with a programmable word.

Parameters:
ADDR_W, 11, word address width; DEPTH = 2**ADDR_W
DATA_W, 64, word width; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
RD_LAT, 1, read latency in cycles for both ports; legal values 1 or 2 (2 adds an output register)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ppu_rden  in  1  PPU read request, one per cycle
ppu_addr  in  ADDR_W  PPU read address
ppu_rddata  out  DATA_W  PPU read data
ppu_rdvalid  out  1  ppu_rddata valid
cpu_req  in  1  CPU access request, held until ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_byteena  in  BE_W  CPU write byte lanes
cpu_wrdata  in  DATA_W  CPU write data
cpu_ack  out  1  request accepted this cycle
cpu_rddata  out  DATA_W  CPU read data
cpu_rdvalid  out  1  cpu_rddata valid
clr_start  in  1  pulse: begin clear
clr_value  in  DATA_W  fill word, sampled on clr_start
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse on clear completion

Behaviour:
- Reset values: ppu_rdvalid=0, cpu_rdvalid=0, clr_busy=0, clr_done=0, ppu_rddata=0, cpu_rddata=0; FSM in IDLE; clear counter=0. RAM contents are not reset.
- FSM states:
  - IDLE -> CLEAR on clr_start.
  - CLEAR -> DONE when the counter reaches DEPTH-1 and that word is written.
  - DONE -> IDLE after one cycle; clr_done=1 in DONE only.
- clr_busy=1 in CLEAR and DONE.
- CLEAR:
  - Port B writes the latched clr_value to address = counter, all byte lanes enabled, one word per cycle.
  - The counter is ADDR_W+1 bits wide so DEPTH is reachable without wrap; the clear takes exactly DEPTH cycles.
  - clr_start during CLEAR or DONE is ignored.
- cpu_ack is combinational: cpu_ack = cpu_req & (state==IDLE) & ~clr_start.
  - clr_start beats a simultaneous cpu_req; the request stays pending and is acked after DONE.
- CPU write:
  - Performed in the ack cycle.
  - Only lanes with cpu_byteena[k]=1 are updated; byteena=0 writes nothing but is still acked.
  - No rdvalid is generated.
- CPU read:
  - Issued in the ack cycle.
  - cpu_rdvalid pulses exactly RD_LAT cycles after ack, with cpu_rddata valid in the same cycle.
  - cpu_rddata holds its value until the next read completes.
- PPU port:
  - Never stalled, including during CLEAR.
  - ppu_rdvalid = ppu_rden delayed RD_LAT cycles; ppu_rddata is updated only when valid.
  - Back-to-back reads give full throughput.
- Same-address collision (port B write and port A read in the same cycle): port A returns the old data. A CPU read after a CPU write to the same address returns the new data.
- Reset mid-CLEAR:
  - Returns to IDLE with clr_busy=0 and no clr_done pulse.
  - In-flight valid pipelines are flushed.
  - RAM is partially cleared; this is legal.
- Address width is exact; no out-of-range addresses exist.

Decomposition:
- Package vram_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR, DONE);
  - the RD_LAT legality constants;
  - the per-region ADDR_W/DATA_W localparams for tile, pattern, palette and sprite.
- Sub-module vram_dpram:
  - Inferred true dual-port RAM, 1-cycle registered outputs, byte-enable on port B, old-data read-during-write.
  - vram_region adds the optional second output stage, the valid pipelines, the FSM and the port-B mux.

Test Plan:
- CPU write then read, RD_LAT=1: write addr 0x010, data 0x1122334455667788, byteena 0xFF; then read 0x010 -> cpu_rdvalid 1 cycle after ack, data 0x1122334455667788.
- Byte lanes: write 0xFFFF_FFFF_FFFF_FFFF to addr 5 with byteena 0x0F over prior 0 -> readback 0x00000000FFFFFFFF.
- Clear, ADDR_W=4:
  - clr_start with clr_value=0xA5A5...: clr_busy high for 17 cycles (16 CLEAR + DONE), clr_done pulses once.
  - PPU reads of all 16 addresses afterwards return 0xA5A5....
- Arbitration: cpu_req and clr_start in the same cycle -> no ack for 17 cycles, then ack in the first IDLE cycle; the CPU write survives the clear.
- RD_LAT=2 PPU streaming: ppu_rden high for 8 cycles at addrs 0..7 -> ppu_rdvalid high for 8 cycles starting 2 cycles later, in address order. A collision write to addr 3 in the cycle addr 3 is read returns the old data.
- Reset asserted at counter=7 of a clear -> all outputs 0 immediately, no clr_done; a new clr_start after reset runs a full DEPTH-cycle clear.
